jtdd_prom_we: RTL

JTDD_PROM_WE -- requirements
Module: jtdd_prom_we

---
 rtl/jtdd_pkg.sv | 42 ++++
 rtl/jtdd_wrfifo.sv | 51 +++++
 rtl/jtdd_prom_we.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/jtdd_pkg.sv
// Shared Double Dragon ROM-download layout: region offsets in the download
// stream, SDRAM word destinations and byte-lane mask encodings.
package jtdd_pkg;

    // Byte offsets of each region in the ioctl download stream
    localparam logic [21:0] JTDD_CHAR_START = 22'h5_0000;
    localparam logic [21:0] JTDD_SCR_START  = 22'h5_8000;
    localparam logic [21:0] JTDD_OBJ_START  = 22'h9_8000;
    localparam logic [21:0] JTDD_PROM_START = 22'h11_8000;

    // SDRAM word destinations of the interleaved regions
    localparam logic [21:0] JTDD_SCR_ADDR   = 22'h4_0000;
    localparam logic [21:0] JTDD_OBJ_ADDR   = 22'h8_0000;

    // Cycles dwnld_busy is stretched after the last SDRAM write
    localparam int          JTDD_TAIL       = 16;

    // Active-low byte-lane enables for a 16-bit SDRAM word
    localparam logic [1:0]  MASK_LOW  = 2'b10;
    localparam logic [1:0]  MASK_HIGH = 2'b01;
    localparam logic [1:0]  MASK_NONE = 2'b11;

    typedef enum logic [2:0] {
        REG_LINEAR,
        REG_CHAR,
        REG_SCR,
        REG_OBJ,
        REG_PROM
    } region_t;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } prog_entry_t;

    // Byte-lane mask for a byte landing in the high or low half of a word
    function automatic logic [1:0] lane_mask(input logic high);
        return high ? MASK_HIGH : MASK_LOW;
    endfunction

endpackage

// File: rtl/jtdd_wrfifo.sv
// Two-entry write buffer between the download decoder and the SDRAM port.
// Push and pop may happen together at any occupancy, including full.
module jtdd_wrfifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    // A pop frees the head slot, so a simultaneous push into a full FIFO fits
    assign do_pop  = pop & (count != 2'd0);
    assign do_push = push & ((count != 2'd2) | do_pop);

    // Entry storage
    // NOTE: storage is deliberately not reset; count decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; rst flushes every pending entry
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/jtdd_prom_we.sv
// Maps the byte-wide ROM download stream onto 16-bit SDRAM words, diverts
// the priority PROM bytes to a dedicated write strobe and tracks busy/error.
module jtdd_prom_we
    import jtdd_pkg::*;
#(
    parameter logic [21:0] CHAR_START = JTDD_CHAR_START,
    parameter logic [21:0] SCR_START  = JTDD_SCR_START,
    parameter logic [21:0] OBJ_START  = JTDD_OBJ_START,
    parameter logic [21:0] PROM_START = JTDD_PROM_START,
    parameter logic [21:0] SCR_ADDR   = JTDD_SCR_ADDR,
    parameter logic [21:0] OBJ_ADDR   = JTDD_OBJ_ADDR,
    parameter int          TAIL       = JTDD_TAIL      // must be >= 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        sdram_ack,
    output logic        prom_prio_we,
    output logic        dwnld_busy,
    output logic        dwnld_err
);

    localparam int TAIL_W = $clog2(TAIL + 1);

    region_t            region;
    logic [21:0]        base;
    logic [21:0]        off;
    prog_entry_t        entry;
    prog_entry_t        head;
    logic               accept;
    logic               sdram_req;
    logic               prom_req;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               prom_we_q;
    logic [7:0]         prom_addr_q;
    logic [7:0]         prom_data_q;
    logic               err_q;
    logic [TAIL_W-1:0]  tail_cnt;

    assign accept = downloading & ioctl_wr;

    // Region decode and address/lane mapping of the incoming byte
    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        region    = REG_LINEAR;
        base      = '0;
        entry     = '{addr: '0, data: ioctl_data, mask: MASK_NONE};
        sdram_req = 1'b0;
        prom_req  = 1'b0;

        if (ioctl_addr >= PROM_START) begin
            region = REG_PROM;
            base   = PROM_START;
        end else if (ioctl_addr >= OBJ_START) begin
            region = REG_OBJ;
            base   = OBJ_START;
        end else if (ioctl_addr >= SCR_START) begin
            region = REG_SCR;
            base   = SCR_START;
        end else if (ioctl_addr >= CHAR_START) begin
            region = REG_CHAR;
        end
        off = ioctl_addr - base;

        case (region)
            REG_LINEAR, REG_CHAR: begin
                entry.addr = {1'b0, ioctl_addr[21:1]};
                entry.mask = lane_mask(ioctl_addr[0]);
                sdram_req  = accept;
            end
            REG_SCR: begin
                // First 128 kB fill the low bytes, second 128 kB the high bytes
                entry.addr = SCR_ADDR + {5'd0, off[16:0]};
                entry.mask = lane_mask(off[17]);
                sdram_req  = accept;
            end
            REG_OBJ: begin
                entry.addr = OBJ_ADDR + {4'd0, off[17:0]};
                entry.mask = lane_mask(off[18]);
                sdram_req  = accept;
            end
            REG_PROM: begin
                // Only the 256 PROM bytes are kept; anything beyond is dropped
                prom_req = accept & (off[21:8] == 14'd0);
            end
            default: ;
        endcase
    end

    // The head is consumed only while it is actually being presented
    assign pop = prog_we & sdram_ack;

    jtdd_wrfifo #(
        .WIDTH ($bits(prog_entry_t))
    ) u_wrfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sdram_req),
        .pop   (pop),
        .din   (entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // One-cycle PROM write strobe with its captured address and byte
    always_ff @(posedge clk) begin
        if (rst) begin
            prom_we_q   <= 1'b0;
            prom_addr_q <= 8'd0;
            prom_data_q <= 8'd0;
        end else begin
            prom_we_q <= prom_req;
            if (prom_req) begin
                prom_addr_q <= off[7:0];
                prom_data_q <= ioctl_data;
            end
        end
    end

    // Sticky overflow: a byte arrived with the buffer full and nothing leaving
    always_ff @(posedge clk) begin
        if (rst)                                 err_q <= 1'b0;
        else if (sdram_req & fifo_full & ~pop)   err_q <= 1'b1;
    end

    // Busy tail: held at TAIL while activity lasts, then counts down to zero
    always_ff @(posedge clk) begin
        if (rst)                              tail_cnt <= '0;
        else if (downloading | ~fifo_empty)   tail_cnt <= TAIL_W'(TAIL);
        else if (tail_cnt != '0)              tail_cnt <= tail_cnt - 1'b1;
    end

    // SDRAM port shows the FIFO head except during a PROM strobe cycle
    always_comb begin
        prog_addr = '0;
        prog_data = '0;
        prog_mask = MASK_NONE;
        if (prom_we_q) begin
            prog_addr = {14'd0, prom_addr_q};
            prog_data = prom_data_q;
        end else if (!fifo_empty) begin
            prog_addr = head.addr;
            prog_data = head.data;
            prog_mask = head.mask;
        end
    end

    assign prog_we      = ~fifo_empty & ~prom_we_q;
    assign prom_prio_we = prom_we_q;
    assign dwnld_err    = err_q;
    assign dwnld_busy   = downloading | ~fifo_empty | (tail_cnt != '0);

endmodule
